// File: rtl/debounce_ctrl_pkg.sv
// Shared types and constants for the multi-channel debounce controller.
// Channel FSM states and config-port register addresses.
package debounce_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } ch_state_e;

    localparam logic [1:0] ADDR_PRESC = 2'd0;
    localparam logic [1:0] ADDR_DELAY = 2'd1;
    localparam logic [1:0] ADDR_EN    = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: qualifies a synchronized level against a tick-counted delay
// and emits a filtered level plus registered one-clock rise/fall events.
module debounce_channel
    import debounce_ctrl_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tick,
    input  logic          en,
    input  logic          din,
    input  logic [DW-1:0] delay,
    output logic          dout,
    output logic          rise_evt,
    output logic          fall_evt,
    output ch_state_e     state
);

    localparam logic [DW:0] ONE_W = (DW+1)'(1);

    ch_state_e     state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [DW:0]   cnt_inc;
    logic          reached;
    logic          delay_le1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A delay of 0 or 1 means a single agreeing tick is enough to switch.
    always_comb begin
        cnt_inc   = {1'b0, cnt_q} + ONE_W;
        reached   = (cnt_inc >= {1'b0, delay});
        delay_le1 = (delay == '0) || (delay == DW'(1));
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din) begin
                        cnt_d   = DW'(1);
                        state_d = delay_le1 ? ST_ACTIVE : ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    if (!din) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (reached) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[DW-1:0];
                    end
                end
                ST_ACTIVE: begin
                    if (!din) begin
                        cnt_d   = DW'(1);
                        state_d = delay_le1 ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (din) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else if (reached) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[DW-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Events come from tick-time transitions only, so a disable never produces a fall.
    always_comb begin
        dout_d = (state_d == ST_ACTIVE) || (state_d == ST_RELEASE);
        rise_d = en && tick && ((state_q == ST_IDLE) || (state_q == ST_QUAL))
                 && (state_d == ST_ACTIVE);
        fall_d = en && tick && ((state_q == ST_ACTIVE) || (state_q == ST_RELEASE))
                 && (state_d == ST_IDLE);
    end

    assign dout     = dout_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;
    assign state    = state_q;

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-channel debounce controller: shared prescaler, config register port,
// per-channel filters, sticky pending flags and a combined interrupt.
module debounce_ctrl
    import debounce_ctrl_pkg::*;
#(
    parameter int CH = 4,
    parameter int DW = 4,
    parameter int PW = 8,
    localparam int CW = $clog2(CH),
    localparam int WW = (PW > CH) ? ((PW > DW) ? PW : DW) : ((CH > DW) ? CH : DW)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [CH-1:0] din,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_ch,
    input  logic [WW-1:0] cfg_wdata,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] rise_evt,
    output logic [CH-1:0] fall_evt,
    output logic [CH-1:0] pending,
    output logic          irq
);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] presc_cur_q, presc_cur_d;
    logic [DW-1:0] delay_q [CH];
    logic [DW-1:0] delay_d [CH];
    logic [CH-1:0] en_q, en_d;
    logic [CH-1:0] edge_q, edge_d;
    logic [CH-1:0] pending_q, pending_d;
    logic          tick;
    logic          target_busy;
    ch_state_e     ch_state [CH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt_q      <= '0;
            presc_q     <= '0;
            presc_cur_q <= '0;
            en_q        <= '0;
            edge_q      <= '0;
            pending_q   <= '0;
            for (int i = 0; i < CH; i++) delay_q[i] <= '0;
        end else begin
            pcnt_q      <= pcnt_d;
            presc_q     <= presc_d;
            presc_cur_q <= presc_cur_d;
            en_q        <= en_d;
            edge_q      <= edge_d;
            pending_q   <= pending_d;
            for (int i = 0; i < CH; i++) delay_q[i] <= delay_d[i];
        end
    end

    // The running period only reloads at a tick, so a new prescale never cuts a period short.
    always_comb begin
        tick        = (pcnt_q == presc_cur_q);
        pcnt_d      = tick ? '0 : pcnt_q + PW'(1);
        presc_cur_d = tick ? presc_d : presc_cur_q;
    end

    always_comb begin
        target_busy = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if ((int'(cfg_ch) == i) &&
                ((ch_state[i] == ST_QUAL) || (ch_state[i] == ST_RELEASE)))
                target_busy = 1'b1;
        end
        cfg_ready = !((cfg_addr == ADDR_DELAY) && target_busy);
    end

    always_comb begin
        presc_d = presc_q;
        en_d    = en_q;
        edge_d  = edge_q;
        for (int i = 0; i < CH; i++) delay_d[i] = delay_q[i];
        if (cfg_valid && cfg_ready) begin
            case (cfg_addr)
                ADDR_PRESC: presc_d = cfg_wdata[PW-1:0];
                ADDR_DELAY: begin
                    for (int i = 0; i < CH; i++)
                        if (int'(cfg_ch) == i) delay_d[i] = cfg_wdata[DW-1:0];
                end
                ADDR_EN:    en_d   = cfg_wdata[CH-1:0];
                ADDR_EDGE:  edge_d = cfg_wdata[CH-1:0];
                default:    presc_d = presc_q;
            endcase
        end
    end

    // A set in the same cycle as its clear takes priority.
    always_comb begin
        pending_d = (pending_q & ~clr) | (edge_q & fall_evt) | (~edge_q & rise_evt);
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_channel #(.DW(DW)) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .tick     (tick),
            .en       (en_q[i]),
            .din      (din[i]),
            .delay    (delay_q[i]),
            .dout     (dout[i]),
            .rise_evt (rise_evt[i]),
            .fall_evt (fall_evt[i]),
            .state    (ch_state[i])
        );
    end

    assign pending = pending_q;
    assign irq     = |pending_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed self-checking bench for debounce_ctrl with hand-computed expectations.
module tb_debounce_ctrl;

    localparam int CH = 4;
    localparam int DW = 4;
    localparam int PW = 8;

    logic          clk;
    logic          rstn;
    logic [CH-1:0] din;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_addr;
    logic [1:0]    cfg_ch;
    logic [7:0]    cfg_wdata;
    logic [CH-1:0] clr;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise_evt;
    logic [CH-1:0] fall_evt;
    logic [CH-1:0] pending;
    logic          irq;

    int            checks;
    int            errors;
    logic [CH-1:0] seen_rise;
    logic [CH-1:0] seen_fall;
    logic [CH-1:0] seen_dout;

    debounce_ctrl #(.CH(CH), .DW(DW), .PW(PW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_ch    (cfg_ch),
        .cfg_wdata (cfg_wdata),
        .clr       (clr),
        .dout      (dout),
        .rise_evt  (rise_evt),
        .fall_evt  (fall_evt),
        .pending   (pending),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance n clocks, sampling 1ns after each edge and accumulating activity.
    task automatic stepClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            seen_rise = seen_rise | rise_evt;
            seen_fall = seen_fall | fall_evt;
            seen_dout = seen_dout | dout;
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] d, input int n);
        din = d;
        stepClk(n);
    endtask

    task automatic clearSeen();
        seen_rise = '0;
        seen_fall = '0;
        seen_dout = '0;
    endtask

    task automatic writeCfg(input logic [1:0] a, input logic [1:0] c, input logic [7:0] d);
        int guard;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_ch    = c;
        cfg_wdata = d;
        #1;
        guard = 0;
        while (!cfg_ready && guard < 50) begin
            stepClk(1);
            guard++;
        end
        if (guard >= 50) checkOutput("cfg_timeout", 32'(cfg_ready), 32'd1);
        stepClk(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        din       = '0;
        cfg_valid = 1'b0;
        cfg_addr  = 2'd0;
        cfg_ch    = 2'd0;
        cfg_wdata = '0;
        clr       = '0;
        clearSeen();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        checkOutput("rst_dout", 32'(dout), 32'h0);
        checkOutput("rst_evts", 32'({rise_evt, fall_evt}), 32'h0);
        checkOutput("rst_pending", 32'(pending), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_ready", 32'(cfg_ready), 32'h1);

        // Basic qualification: presc=0, ch0 delay=3
        writeCfg(2'd1, 2'd0, 8'd3);
        writeCfg(2'd2, 2'd0, 8'b0001);
        applyStimulus(4'b0001, 1);
        checkOutput("t1_dout_t1", 32'(dout[0]), 32'h0);
        stepClk(1);
        checkOutput("t1_dout_t2", 32'(dout[0]), 32'h0);
        stepClk(1);
        checkOutput("t1_dout_t3", 32'(dout[0]), 32'h1);
        checkOutput("t1_rise_t3", 32'(rise_evt), 32'h1);
        checkOutput("t1_pend_t3", 32'(pending), 32'h0);
        stepClk(1);
        checkOutput("t1_rise_off", 32'(rise_evt), 32'h0);
        checkOutput("t1_pending", 32'(pending), 32'h1);
        checkOutput("t1_irq", 32'(irq), 32'h1);

        // Release with delay=3, then clear pending
        applyStimulus(4'b0000, 1);
        checkOutput("t2_rel_dout", 32'(dout[0]), 32'h1);
        stepClk(2);
        checkOutput("t2_fall", 32'(fall_evt), 32'h1);
        checkOutput("t2_dout_low", 32'(dout[0]), 32'h0);
        clr = 4'b0001;
        stepClk(1);
        clr = '0;
        checkOutput("t2_fall_off", 32'(fall_evt), 32'h0);
        checkOutput("t2_clr", 32'(pending), 32'h0);

        // Glitch: two ticks high against delay=3
        clearSeen();
        applyStimulus(4'b0001, 2);
        cfg_addr  = 2'd1;
        cfg_ch    = 2'd0;
        #1;
        checkOutput("t2_qual_ready", 32'(cfg_ready), 32'h0);
        applyStimulus(4'b0000, 1);
        #1;
        checkOutput("t2_idle_ready", 32'(cfg_ready), 32'h1);
        checkOutput("t2_glitch_rise", 32'(seen_rise), 32'h0);
        checkOutput("t2_glitch_dout", 32'(seen_dout), 32'h0);
        checkOutput("t2_glitch_pend", 32'(pending), 32'h0);

        // presc=4 (period 5 clk), delay=2
        writeCfg(2'd1, 2'd0, 8'd2);
        writeCfg(2'd0, 2'd0, 8'd4);
        applyStimulus(4'b0001, 9);
        checkOutput("t3_dout_e9", 32'(dout[0]), 32'h0);
        stepClk(1);
        checkOutput("t3_dout_e10", 32'(dout[0]), 32'h1);
        checkOutput("t3_rise_e10", 32'(rise_evt), 32'h1);
        stepClk(1);
        checkOutput("t3_rise_e11", 32'(rise_evt), 32'h0);
        clearSeen();
        applyStimulus(4'b0000, 4);
        applyStimulus(4'b0001, 6);
        checkOutput("t3_short_fall", 32'(seen_fall), 32'h0);
        checkOutput("t3_short_dout", 32'(dout[0]), 32'h1);
        applyStimulus(4'b0000, 8);
        checkOutput("t3_fall_e29", 32'(fall_evt), 32'h0);
        checkOutput("t3_dout_e29", 32'(dout[0]), 32'h1);
        stepClk(1);
        checkOutput("t3_fall_e30", 32'(fall_evt), 32'h1);
        checkOutput("t3_dout_e30", 32'(dout[0]), 32'h0);
        stepClk(1);
        checkOutput("t3_fall_e31", 32'(fall_evt), 32'h0);
        writeCfg(2'd0, 2'd0, 8'd0);
        stepClk(6);

        // Delay write stalls while ch1 qualifies
        writeCfg(2'd1, 2'd1, 8'd4);
        writeCfg(2'd2, 2'd0, 8'b0011);
        applyStimulus(4'b0010, 1);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd1;
        cfg_ch    = 2'd1;
        cfg_wdata = 8'd2;
        #1;
        checkOutput("t4_stall_q1", 32'(cfg_ready), 32'h0);
        stepClk(1);
        checkOutput("t4_stall_q2", 32'(cfg_ready), 32'h0);
        stepClk(1);
        checkOutput("t4_stall_q3", 32'(cfg_ready), 32'h0);
        stepClk(1);
        checkOutput("t4_ready_act", 32'(cfg_ready), 32'h1);
        checkOutput("t4_dout", 32'(dout[1]), 32'h1);
        stepClk(1);
        cfg_valid = 1'b0;
        applyStimulus(4'b0000, 1);
        checkOutput("t4_rel_fall", 32'(fall_evt), 32'h0);
        stepClk(1);
        checkOutput("t4_new_delay", 32'(fall_evt), 32'h2);

        // Fall-edge pending on ch2 with colliding clear
        clr = 4'hF;
        stepClk(1);
        clr = '0;
        writeCfg(2'd1, 2'd2, 8'd1);
        writeCfg(2'd3, 2'd0, 8'b0100);
        writeCfg(2'd2, 2'd0, 8'b0111);
        applyStimulus(4'b0100, 1);
        checkOutput("t5_rise", 32'(rise_evt), 32'h4);
        stepClk(1);
        checkOutput("t5_no_pend_rise", 32'(pending), 32'h0);
        applyStimulus(4'b0000, 1);
        checkOutput("t5_fall", 32'(fall_evt), 32'h4);
        clr = 4'b0100;
        stepClk(1);
        clr = '0;
        checkOutput("t5_set_wins", 32'(pending), 32'h4);
        checkOutput("t5_irq", 32'(irq), 32'h1);
        clr = 4'b0100;
        stepClk(1);
        clr = '0;
        checkOutput("t5_clr_alone", 32'(pending), 32'h0);
        checkOutput("t5_irq_off", 32'(irq), 32'h0);

        // Reset while ch3 releases
        writeCfg(2'd1, 2'd3, 8'd5);
        writeCfg(2'd2, 2'd0, 8'b1111);
        applyStimulus(4'b1000, 5);
        checkOutput("t6_dout_act", 32'(dout[3]), 32'h1);
        applyStimulus(4'b0000, 1);
        checkOutput("t6_dout_rel", 32'(dout[3]), 32'h1);
        checkOutput("t6_pend_pre", 32'(pending), 32'h8);
        cfg_addr = 2'd1;
        cfg_ch   = 2'd3;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("t6_rst_dout", 32'(dout), 32'h0);
        checkOutput("t6_rst_evts", 32'({rise_evt, fall_evt}), 32'h0);
        checkOutput("t6_rst_pend", 32'(pending), 32'h0);
        checkOutput("t6_rst_irq", 32'(irq), 32'h0);
        checkOutput("t6_rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        rstn = 1'b1;
        writeCfg(2'd2, 2'd0, 8'b1000);
        clearSeen();
        stepClk(8);
        checkOutput("t6_no_stale_evt", 32'({seen_rise, seen_fall}), 32'h0);
        checkOutput("t6_no_stale_dout", 32'(seen_dout), 32'h0);
        checkOutput("t6_no_stale_pend", 32'(pending), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
